// File: rtl/muldiv_if.sv
// Request/response bundle between the controller and the multi-cycle multiply/divide unit.
interface muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers: shift-add multiply and
// restoring divide, WIDTH iterations each, followed by one sign fix-up cycle.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic     clk,
    input logic     reset,
    muldiv_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    state_e             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     rem;     // upper half: accumulator (MUL) / partial remainder (DIV)
    logic [WIDTH-1:0]   quo;     // lower half: multiplier (MUL) / dividend-quotient (DIV)
    logic [WIDTH-1:0]   opd;     // multiplicand (MUL) / divisor (DIV)
    logic               qsign;
    logic               rsign;
    logic               is_div;
    logic               is_dz;

    logic               sgn;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_neg;

    always_comb begin
        sgn      = ~bus.op[0];
        abs_a    = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        abs_b    = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        mul_sum  = quo[0] ? ({1'b0, rem[WIDTH-1:0]} + {1'b0, opd}) : rem;
        div_sh   = {rem[WIDTH-1:0], quo[WIDTH-1]};
        div_diff = div_sh - {1'b0, opd};
        prod     = {rem[WIDTH-1:0], quo};
        prod_neg = -prod;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StIdle;
            cnt          <= '0;
            rem          <= '0;
            quo          <= '0;
            opd          <= '0;
            qsign        <= 1'b0;
            rsign        <= 1'b0;
            is_div       <= 1'b0;
            is_dz        <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
            bus.hi       <= '0;
            bus.lo       <= '0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.start) begin
                        if (!bus.op[2]) begin
                            bus.busy     <= 1'b1;
                            bus.div_zero <= 1'b0;
                            cnt          <= '0;
                            rem          <= '0;
                            is_div       <= bus.op[1];
                            is_dz        <= bus.op[1] && (bus.b == '0);
                            qsign        <= sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            rsign        <= sgn & bus.a[WIDTH-1];
                            if (bus.op[1]) begin
                                quo   <= abs_a;
                                opd   <= abs_b;
                                state <= StDiv;
                            end else begin
                                quo   <= abs_b;
                                opd   <= abs_a;
                                state <= StMul;
                            end
                        end else if (bus.op[1:0] == 2'b00) begin
                            bus.hi   <= bus.a;
                            bus.done <= 1'b1;
                        end else if (bus.op[1:0] == 2'b01) begin
                            bus.lo   <= bus.a;
                            bus.done <= 1'b1;
                        end
                    end
                end
                StMul: begin
                    {rem, quo} <= {mul_sum, quo} >> 1;
                    cnt        <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) state <= StFix;
                end
                StDiv: begin
                    if (!div_diff[WIDTH]) begin
                        rem <= div_diff;
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= div_sh;
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) state <= StFix;
                end
                StFix: begin
                    if (!is_div) begin
                        {bus.hi, bus.lo} <= qsign ? prod_neg : prod;
                    end else if (is_dz) begin
                        // rem holds |a| here; restoring a's sign yields the original a
                        bus.lo       <= '1;
                        bus.hi       <= rsign ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                        bus.div_zero <= 1'b1;
                    end else begin
                        bus.lo <= qsign ? -quo : quo;
                        bus.hi <= rsign ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                    end
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    state    <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver queues expected HI/LO/div_zero per operation,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic reset;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1, expected done=0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_hi"}, bus.hi, e.hi);
                check({e.name, "_lo"}, bus.lo, e.lo);
                check({e.name, "_div_zero"}, bus.div_zero, e.dz);
            end
        end
    end

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input logic edz,
                          input string name, input int inject_at);
        logic [31:0] hi0, lo0;
        int          busy_cyc, guard;
        bit          moved;
        sb.push_back('{name, eh, el, edz});
        hi0 = bus.hi;
        lo0 = bus.lo;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        busy_cyc  = 0;
        guard     = 0;
        moved     = 1'b0;
        while (bus.done !== 1'b1 && guard < 100) begin
            if (bus.busy === 1'b1) busy_cyc++;
            if (bus.hi !== hi0 || bus.lo !== lo0) moved = 1'b1;
            guard++;
            if (guard == inject_at) begin
                bus.start = 1'b1;
                bus.op    = 3'b011;
                bus.a     = 32'd9;
                bus.b     = 32'd3;
            end
            @(negedge clk);
            bus.start = 1'b0;
        end
        check({name, "_busy_cycles"}, busy_cyc, 33);
        check({name, "_busy_low_at_done"}, bus.busy, 1'b0);
        check({name, "_hilo_stable"}, moved, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_done", bus.done, 1'b0);
        check("reset_div_zero", bus.div_zero, 1'b0);
        check("reset_hi", bus.hi, 32'h0);
        check("reset_lo", bus.lo, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        run_op(3'b000, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, "mult_m3x5", 0);
        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0, "multu_max", 0);
        run_op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, "mult_m1xm1", 0);
        run_op(3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_m7d2", 0);
        run_op(3'b010, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0, "div_7dm2", 0);
        run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, "div_ovf", 0);
        run_op(3'b011, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF, 1'b1, "divu_by0", 0);

        // MTHI then MTLO back to back; div_zero must survive both
        bus.start = 1'b1;
        bus.op    = 3'b100;
        bus.a     = 32'hDEADBEEF;
        sb.push_back('{"mthi", 32'hDEADBEEF, 32'hFFFFFFFF, 1'b1});
        @(negedge clk);
        check("mthi_busy", bus.busy, 1'b0);
        bus.op = 3'b101;
        bus.a  = 32'h0BADF00D;
        sb.push_back('{"mtlo", 32'hDEADBEEF, 32'h0BADF00D, 1'b1});
        @(negedge clk);
        bus.start = 1'b0;
        check("mtlo_busy", bus.busy, 1'b0);
        @(negedge clk);

        // Reserved op: no done, no register change
        bus.start = 1'b1;
        bus.op    = 3'b110;
        bus.a     = 32'h12345678;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("nop_busy", bus.busy, 1'b0);
        check("nop_hi", bus.hi, 32'hDEADBEEF);
        check("nop_lo", bus.lo, 32'h0BADF00D);

        run_op(3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "divu_100d7", 0);
        run_op(3'b001, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, "multu_ignore_start", 10);

        // Reset mid-operation: nothing queued, so any done pulse is flagged by the monitor
        bus.start = 1'b1;
        bus.op    = 3'b001;
        bus.a     = 32'd3;
        bus.b     = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        check("pre_reset_busy", bus.busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midop_reset_busy", bus.busy, 1'b0);
        check("midop_reset_done", bus.done, 1'b0);
        check("midop_reset_hi", bus.hi, 32'h0);
        check("midop_reset_lo", bus.lo, 32'h0);
        repeat (40) @(negedge clk);
        check("post_reset_busy", bus.busy, 1'b0);

        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS single-cycle core. It replaces the single-cycle combinational multiply.
- Sequences MULT/MULTU by radix-2 shift-add and DIV/DIVU by restoring division, 32 iterations each.
- The controller stalls the fetch stage on `busy` whenever MFHI or MFLO is decoded while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH bits each; iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only while idle (busy=0)
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op
- a  in  WIDTH  rs operand (multiplicand / dividend / MTHI/MTLO source)
- b  in  WIDTH  rt operand (multiplier / divisor)
- busy  out  1  operation in progress; HI/LO not valid
- done  out  1  one-cycle pulse; HI/LO updated and valid
- div_zero  out  1  sticky flag: last DIV/DIVU had b==0; cleared on next accepted start
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (sync, any state, including mid-operation):
  - state=IDLE; hi=lo=0; busy=done=div_zero=0.
  - Iteration counter and work registers are cleared.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start=1, op=MULT/MULTU/DIVU/DIV (edge E0):
  - Latch operands and clear div_zero.
  - Go to MUL for MULT/MULTU, or DIV for DIV/DIVU.
  - busy=1 from the cycle after E0.
  - Signed ops latch magnitudes |a|, |b| and record the result signs:
    - quotient/product sign = a[MSB]^b[MSB]
    - remainder sign = a[MSB]
  - Unsigned ops record both signs as 0.
- IDLE, start=1, op=MTHI/MTLO:
  - hi (or lo) is written with a at E0; busy stays 0.
  - done pulses in the next cycle; div_zero is unchanged.
- IDLE, start=1, op=110/111: no effect, no done.
- start while busy=1: ignored; no queuing; operands are not re-latched.
- MUL, edges E1..E32:
  - Per edge, add the multiplicand to the upper half of a 2*WIDTH accumulator if multiplier LSB=1.
  - Then shift the accumulator right 1.
  - Carry out of the add is kept; the accumulator is WIDTH+1 bits wide in its upper half.
- DIV, edges E1..E32:
  - Per edge, shift the remainder:quotient register left 1.
  - Trial-subtract the divisor from the remainder.
  - If non-negative, keep the difference and set quotient LSB=1; otherwise restore and set LSB=0.
- Counter: counts 0..WIDTH-1; the transition to FIX happens on the edge where the count equals WIDTH-1.
- FIX, edge E33:
  - Apply two's-complement negation per the recorded signs.
  - MUL: write hi:lo = 64-bit product.
  - DIV: write lo = quotient, hi = remainder.
  - Go to IDLE.
  - Cycle after E33: busy=0, done=1 for exactly one cycle.
- Latency and throughput:
  - busy is high for 33 cycles; a new start is accepted in the same cycle done is high.
  - Back-to-back throughput is one operation per 34 cycles.
- Divide by zero (b==0):
  - Full latency is kept; div_zero=1 at done.
  - Result: lo=all-ones, hi=a (original, un-negated a).
  - The sign fix-up is suppressed.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, div_zero=0.
- Register stability: hi/lo hold their previous values throughout busy and change only at E33 or at an MTHI/MTLO edge.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> after 33 busy cycles, done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT with the same operands -> hi=0, lo=1.
- Signed division:
  - DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> div_zero=1, lo=0xFFFFFFFF, hi=0x1234. A following DIVU 100/7 clears div_zero and gives lo=14, hi=2.
- Busy and reset handling:
  - Start MULTU 3*4; at cycle 10 assert start with DIVU 9/3 -> ignored, final hi=0, lo=12.
  - Repeat the MULTU; assert reset at cycle 20 -> next cycle busy=0, hi=lo=0, no done pulse.
- MTHI a=0xDEADBEEF, then MTLO a=0x0BADF00D on consecutive cycles -> busy never asserts, done pulses twice, hi=0xDEADBEEF, lo=0x0BADF00D.
